// File: rtl/iob_ram_arbiter_pkg.sv
// iob_ram_arbiter_pkg: shared constants and types for the IOb RAM arbiter
package iob_ram_arbiter_pkg;
  localparam int POLICY_RR    = 0;
  localparam int POLICY_FIXED = 1;
  localparam int WORD_LSB     = 2;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
endpackage

// File: rtl/iob_ram_arb_sel.sv
// iob_ram_arb_sel: combinational winner selection between the two masters
module iob_ram_arb_sel
  import iob_ram_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = 3
) (
  input  logic [1:0]       eligible,
  input  logic             last,
  input  logic [CNT_W-1:0] cnt,
  input  logic             policy,
  output logic             winner,
  output logic             any
);
  // a lone requester always wins; a tie goes by rotation or by priority with the starvation cap
  always_comb begin
    any    = |eligible;
    winner = &eligible ? (policy ? cnt == CNT_W'(MAX_CONSEC) : ~last) : eligible[1];
  end
endmodule

// File: rtl/iob_ram_arbiter.sv
// iob_ram_arbiter: shares one single-port byte-enabled RAM between two IOb masters
module iob_ram_arbiter
  import iob_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RAM_ADDR_W = 13,
  parameter int POLICY     = 0,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  m0_valid_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_wstrb_i,
  output logic [DATA_W-1:0]     m0_rdata_o,
  output logic                  m0_ready_o,
  input  logic                  m1_valid_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  m1_ready_o,
  output logic                  ram_en_o,
  output logic [RAM_ADDR_W-3:0] ram_addr_o,
  output logic [DATA_W/8-1:0]   ram_we_o,
  output logic [DATA_W-1:0]     ram_din_o,
  input  logic [DATA_W-1:0]     ram_dout_i,
  output logic                  grant_o,
  output logic                  busy_o
);
  localparam int CNT_W = $clog2(MAX_CONSEC + 1);
  state_t           state, state_nxt;
  logic             grant, winner, any;
  logic [1:0]       eligible;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             unused_addr;
  assign unused_addr = ^{m0_addr_i[ADDR_W-1:RAM_ADDR_W], m0_addr_i[WORD_LSB-1:0],
                         m1_addr_i[ADDR_W-1:RAM_ADDR_W], m1_addr_i[WORD_LSB-1:0]};
  // the master being answered has a stale valid this cycle, so it sits out
  assign eligible   = {m1_valid_i & ~(state == RESP & grant), m0_valid_i & ~(state == RESP & ~grant)};
  assign m0_ready_o = state == RESP & ~grant;
  assign m1_ready_o = state == RESP & grant;
  assign m0_rdata_o = ram_dout_i;
  assign m1_rdata_o = ram_dout_i;
  assign grant_o    = grant;
  assign busy_o     = state == RESP;
  iob_ram_arb_sel #(.MAX_CONSEC(MAX_CONSEC), .CNT_W(CNT_W)) u_sel (
    .eligible(eligible),
    .last    (grant),
    .cnt     (cnt),
    .policy  (1'(POLICY == POLICY_FIXED)),
    .winner  (winner),
    .any     (any)
  );
  // issue the winner straight onto the RAM port and track the master-0 streak
  always_comb begin
    state_nxt  = any ? RESP : IDLE;
    ram_en_o   = any;
    ram_addr_o = winner ? m1_addr_i[RAM_ADDR_W-1:WORD_LSB] : m0_addr_i[RAM_ADDR_W-1:WORD_LSB];
    ram_we_o   = !any ? '0 : winner ? m1_wstrb_i : m0_wstrb_i;
    ram_din_o  = winner ? m1_wdata_i : m0_wdata_i;
    cnt_nxt    = (!m1_valid_i || (any && winner)) ? '0 :
                 (any && cnt != CNT_W'(MAX_CONSEC)) ? cnt + CNT_W'(1) : cnt;
  end
  // state, last grant and streak counter; grant resets to 1 so master 0 wins the first tie
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      grant <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (any) grant <= winner;
    end
  end
endmodule

// File: tb/tb_iob_ram_arbiter.sv
// tb_iob_ram_arbiter: round-robin and fixed-priority arbiters checked by table, corner sequences and random traffic
module tb_iob_ram_arbiter;
  localparam int MAXC = 4;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b1;
  always #5 clk = ~clk;

  logic        vld      [2][2];
  logic [31:0] addr     [2][2];
  logic [31:0] wdata    [2][2];
  logic [3:0]  wstrb    [2][2];
  logic [31:0] rdata    [2][2];
  logic        rdy      [2][2];
  logic        ram_en   [2];
  logic [10:0] ram_addr [2];
  logic [3:0]  ram_we   [2];
  logic [31:0] ram_din  [2];
  logic        grant    [2];
  logic        busy     [2];

  for (genvar g = 0; g < 2; g++) begin : gd
    logic [31:0] mem [2048];
    logic [31:0] dout;
    iob_ram_arbiter #(.POLICY(g), .MAX_CONSEC(MAXC)) dut (
      .clk_i(clk), .arst_n_i(rst_n),
      .m0_valid_i(vld[g][0]), .m0_addr_i(addr[g][0]), .m0_wdata_i(wdata[g][0]), .m0_wstrb_i(wstrb[g][0]),
      .m0_rdata_o(rdata[g][0]), .m0_ready_o(rdy[g][0]),
      .m1_valid_i(vld[g][1]), .m1_addr_i(addr[g][1]), .m1_wdata_i(wdata[g][1]), .m1_wstrb_i(wstrb[g][1]),
      .m1_rdata_o(rdata[g][1]), .m1_ready_o(rdy[g][1]),
      .ram_en_o(ram_en[g]), .ram_addr_o(ram_addr[g]), .ram_we_o(ram_we[g]), .ram_din_o(ram_din[g]),
      .ram_dout_i(dout), .grant_o(grant[g]), .busy_o(busy[g])
    );
    // behavioural single-port RAM with one-cycle read latency
    always @(posedge clk) begin
      if (clr) for (int i = 0; i < 2048; i++) mem[i] <= '0;
      else if (ram_en[g]) begin
        dout <= mem[ram_addr[g]];
        for (int b = 0; b < 4; b++) if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_din[g][8*b +: 8];
      end
    end
  end

  int          n_cmp = 0, n_bad = 0;
  int          pend [2], lastg [2], cnt [2];
  logic [31:0] shadow [2][2048];
  logic [31:0] prd [2];
  logic        pread [2];
  logic [1:0]  pv [2], prdy [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend[d] = -1; lastg[d] = 1; cnt[d] = 0; pv[d] = 2'b00; prdy[d] = 2'b00; pread[d] = 1'b0;
    end
  endtask

  // reference: who is answered, who is eligible, who wins, and what the RAM holds
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [1:0]  cur, crdy, el, er;
      logic [10:0] wa;
      int          w;
      cur  = {vld[d][1], vld[d][0]};
      crdy = {rdy[d][1], rdy[d][0]};
      er   = 2'b00;
      if (pend[d] >= 0) er[pend[d]] = 1'b1;
      chk($sformatf("ready[%0d]", d), 32'(crdy), 32'(er));
      chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(pend[d] >= 0));
      chk($sformatf("grant[%0d]", d), 32'(grant[d]), 32'(lastg[d]));
      if (pend[d] >= 0 && pread[d]) chk($sformatf("rdata[%0d]", d), rdata[d][pend[d]], prd[d]);
      chk($sformatf("protocol[%0d]", d), 32'((pv[d] & ~cur & ~crdy & ~prdy[d]) == 2'b00), 32'd1);
      el = cur;
      if (pend[d] >= 0) el[pend[d]] = 1'b0;
      w = el == 2'b01 ? 0 : el == 2'b10 ? 1 :
          el == 2'b11 ? (d == 0 ? 1 - lastg[d] : (cnt[d] == MAXC ? 1 : 0)) : -1;
      chk($sformatf("ram_en[%0d]", d), 32'(ram_en[d]), 32'(w >= 0));
      if (w >= 0) begin
        wa = addr[d][w][12:2];
        chk($sformatf("ram_addr[%0d]", d), 32'(ram_addr[d]), 32'(wa));
        chk($sformatf("ram_we[%0d]", d), 32'(ram_we[d]), 32'(wstrb[d][w]));
        chk($sformatf("ram_din[%0d]", d), ram_din[d], wdata[d][w]);
        pread[d] = wstrb[d][w] == 4'h0;
        prd[d]   = shadow[d][wa];
        for (int b = 0; b < 4; b++) if (wstrb[d][w][b]) shadow[d][wa][8*b +: 8] = wdata[d][w][8*b +: 8];
        lastg[d] = w;
      end else chk($sformatf("ram_we_idle[%0d]", d), 32'(ram_we[d]), 32'd0);
      cnt[d]  = (!cur[1] || w == 1) ? 0 : (w == 0 && cnt[d] < MAXC) ? cnt[d] + 1 : cnt[d];
      pend[d] = w;
      pv[d]   = cur;
      prdy[d] = crdy;
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  s0, s1;
    logic        en;
    logic [1:0]  r0, r1;
    logic [10:0] ad0, ad1;
    logic        g0, g1;
    logic [31:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [31:0] a0, logic [3:0] s0, logic [31:0] d0,
                              logic [31:0] a1, logic [3:0] s1, logic [31:0] d1, logic en,
                              logic [1:0] r0, logic [1:0] r1, logic [10:0] ad0, logic [10:0] ad1,
                              logic g0, logic g1, logic [31:0] rd0, logic [31:0] rd1);
    vec_t t;
    t.v = v; t.a0 = a0; t.s0 = s0; t.d0 = d0; t.a1 = a1; t.s1 = s1; t.d1 = d1; t.en = en;
    t.r0 = r0; t.r1 = r1; t.ad0 = ad0; t.ad1 = ad1; t.g0 = g0; t.g1 = g1; t.rd0 = rd0; t.rd1 = rd1;
    return t;
  endfunction

  vec_t tv [18];

  initial begin
    logic [31:0] r;
    logic [1:0]  rr;
    tv[0]  = mk(2'b10, 0, 0, 0, 32'h14, 4'hF, 32'hCAFEBABE, 1, 2'b00, 2'b00, 5, 5, 1, 1, 0, 0);
    tv[1]  = mk(2'b11, 32'h14, 0, 0, 32'h14, 4'hF, 32'hCAFEBABE, 1, 2'b10, 2'b10, 5, 5, 1, 1, 0, 0);
    tv[2]  = mk(2'b01, 32'h14, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 32'hCAFEBABE, 32'hCAFEBABE);
    tv[3]  = mk(2'b10, 0, 0, 0, 32'h20, 4'hF, 32'hAAAAAAAA, 1, 2'b00, 2'b00, 8, 8, 0, 0, 0, 0);
    tv[4]  = mk(2'b10, 0, 0, 0, 32'h20, 4'hF, 32'hAAAAAAAA, 0, 2'b10, 2'b10, 0, 0, 1, 1, 0, 0);
    tv[5]  = mk(2'b10, 0, 0, 0, 32'h20, 4'h5, 32'h11223344, 1, 2'b00, 2'b00, 8, 8, 1, 1, 0, 0);
    tv[6]  = mk(2'b10, 0, 0, 0, 32'h20, 4'h5, 32'h11223344, 0, 2'b10, 2'b10, 0, 0, 1, 1, 0, 0);
    tv[7]  = mk(2'b10, 0, 0, 0, 32'hFFFFE023, 0, 0, 1, 2'b00, 2'b00, 8, 8, 1, 1, 0, 0);
    tv[8]  = mk(2'b10, 0, 0, 0, 32'hFFFFE023, 0, 0, 0, 2'b10, 2'b10, 0, 0, 1, 1, 32'hAA22AA44, 32'hAA22AA44);
    tv[9]  = mk(2'b11, 32'h14, 0, 0, 32'h20, 0, 0, 1, 2'b00, 2'b00, 5, 5, 1, 1, 0, 0);
    tv[10] = mk(2'b11, 32'h14, 0, 0, 32'h20, 0, 0, 1, 2'b01, 2'b01, 8, 8, 0, 0, 32'hCAFEBABE, 32'hCAFEBABE);
    tv[11] = mk(2'b11, 32'h14, 0, 0, 32'h20, 0, 0, 1, 2'b10, 2'b10, 5, 5, 1, 1, 32'hAA22AA44, 32'hAA22AA44);
    tv[12] = mk(2'b01, 32'h14, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 32'hCAFEBABE, 32'hCAFEBABE);
    tv[13] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tv[14] = mk(2'b11, 32'h14, 0, 0, 32'h20, 0, 0, 1, 2'b00, 2'b00, 8, 5, 0, 0, 0, 0);
    tv[15] = mk(2'b11, 32'h14, 0, 0, 32'h20, 0, 0, 1, 2'b10, 2'b01, 5, 8, 1, 0, 32'hAA22AA44, 32'hCAFEBABE);
    tv[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1, 32'hCAFEBABE, 32'hAA22AA44);
    tv[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        vld[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0; wstrb[d][m] = '0;
      end
      for (int i = 0; i < 2048; i++) shadow[d][i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset ready[%0d]", d), 32'({rdy[d][1], rdy[d][0]}), 32'd0);
      chk($sformatf("reset busy[%0d]", d), 32'(busy[d]), 32'd0);
      chk($sformatf("reset grant[%0d]", d), 32'(grant[d]), 32'd1);
    end
    clr = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 18; i++) begin
      for (int d = 0; d < 2; d++) begin
        vld[d][0] = tv[i].v[0]; addr[d][0] = tv[i].a0; wdata[d][0] = tv[i].d0; wstrb[d][0] = tv[i].s0;
        vld[d][1] = tv[i].v[1]; addr[d][1] = tv[i].a1; wdata[d][1] = tv[i].d1; wstrb[d][1] = tv[i].s1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rr = d == 0 ? tv[i].r0 : tv[i].r1;
        chk($sformatf("vec%0d en[%0d]", i, d), 32'(ram_en[d]), 32'(tv[i].en));
        chk($sformatf("vec%0d ready[%0d]", i, d), 32'({rdy[d][1], rdy[d][0]}), 32'(rr));
        chk($sformatf("vec%0d grant[%0d]", i, d), 32'(grant[d]), 32'(d == 0 ? tv[i].g0 : tv[i].g1));
        if (tv[i].en) chk($sformatf("vec%0d addr[%0d]", i, d), 32'(ram_addr[d]), 32'(d == 0 ? tv[i].ad0 : tv[i].ad1));
        if (rr != 2'b00 && (d == 0 ? tv[i].rd0 : tv[i].rd1) != 0)
          chk($sformatf("vec%0d rdata[%0d]", i, d), rdata[d][rr[1] ? 1 : 0], d == 0 ? tv[i].rd0 : tv[i].rd1);
      end
      model_step();
      @(posedge clk);
      #1;
    end
    // reset pulsed while a read response is pending
    for (int d = 0; d < 2; d++) begin
      vld[d][0] = 1'b1; addr[d][0] = 32'h14; wstrb[d][0] = 4'h0; vld[d][1] = 1'b0;
    end
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("pre-reset ready[%0d]", d), 32'(rdy[d][0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid-reset ready[%0d]", d), 32'({rdy[d][1], rdy[d][0]}), 32'd0);
      chk($sformatf("mid-reset busy[%0d]", d), 32'(busy[d]), 32'd0);
      chk($sformatf("mid-reset grant[%0d]", d), 32'(grant[d]), 32'd1);
      vld[d][0] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      vld[d][0] = 1'b1; addr[d][0] = 32'h20;
    end
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) vld[d][0] = 1'b0;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    // random traffic: each master issues a fresh request or idles once its last one is answered
    for (int c = 0; c < 800; c++) begin
      for (int d = 0; d < 2; d++)
        for (int m = 0; m < 2; m++)
          if (!vld[d][m] || prdy[d][m]) begin
            vld[d][m]   = $urandom_range(0, 3) != 0;
            r           = $urandom();
            r[12:2]     = 11'($urandom_range(0, 7));
            addr[d][m]  = r;
            wdata[d][m] = $urandom();
            wstrb[d][m] = $urandom_range(0, 1) != 0 ? 4'($urandom_range(0, 15)) : 4'h0;
          end
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
